onfi_bus_arbiter: RTL and testbench

//   Shares one ONFI pin set between NUM_REQ command engines (get_feature, set_feature, read_id, ...).

---
 rtl/onfi_bus_arbiter_if.sv | 37 +++
 rtl/onfi_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_onfi_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/onfi_bus_arbiter_if.sv
// Signal bundle between the command engines, the ONFI bus arbiter and the pad ring.
// The slave modport is the arbiter's view; master is the engines/pads side.
interface onfi_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DQ_W    = 8
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      done;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      eng_cle;
    logic [NUM_REQ-1:0]      eng_ale;
    logic [NUM_REQ-1:0]      eng_wen;
    logic [NUM_REQ*DQ_W-1:0] eng_dq_o;
    logic [NUM_REQ-1:0]      eng_dq_en;
    logic [NUM_REQ-1:0]      eng_dqs_en;
    logic                    onfi_cen;
    logic                    onfi_cle;
    logic                    onfi_ale;
    logic                    onfi_wen;
    logic [DQ_W-1:0]         onfi_dq_o;
    logic                    onfi_dq_en;
    logic                    onfi_dqs_en;
    logic                    busy;
    logic                    timeout_err;

    modport slave (
        input  req, done, eng_cle, eng_ale, eng_wen, eng_dq_o, eng_dq_en, eng_dqs_en,
        output gnt, onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_o, onfi_dq_en,
               onfi_dqs_en, busy, timeout_err
    );

    modport master (
        output req, done, eng_cle, eng_ale, eng_wen, eng_dq_o, eng_dq_en, eng_dqs_en,
        input  gnt, onfi_cen, onfi_cle, onfi_ale, onfi_wen, onfi_dq_o, onfi_dq_en,
               onfi_dqs_en, busy, timeout_err
    );
endinterface

// File: rtl/onfi_bus_arbiter.sv
// Round-robin owner of the shared ONFI pin set: grants one command engine at a time,
// muxes its pins onto the pads, forces a CE#-high turnaround and aborts stuck owners.
//
//   state | meaning
//   IDLE  | bus free, pins idle, arbitrate among pending requests
//   OWN   | granted engine drives the pins, CE# low, hold timer running
//   TURN  | CE# high turnaround; requests wait until IDLE
module onfi_bus_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DQ_W     = 8,
    parameter int TURN_CYC = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic                onfi_clk,
    input  logic                onfi_rst_n,
    onfi_bus_arbiter_if.slave   bus
);
    localparam int LAST_W = $clog2(NUM_REQ);
    localparam int HOLD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = (TIMEOUT > 0) ? HOLD_W'(TIMEOUT - 1) : '0;
    localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;
    localparam logic [3:0]        TURN_LAST = 4'(TURN_CYC - 1);
    localparam logic [LAST_W-1:0] LAST_RST  = LAST_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [LAST_W-1:0]   last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [3:0]          turn_q, turn_d;
    logic                terr_q, terr_d;

    logic [LAST_W-1:0]   sel;
    logic                found;

    always_ff @(posedge onfi_clk or negedge onfi_rst_n) begin
        if (!onfi_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            hold_q  <= '0;
            turn_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            turn_q  <= turn_d;
            terr_q  <= terr_d;
        end
    end

    // Search starts just past the previous owner so every requester gets a turn.
    always_comb begin
        sel   = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                sel   = LAST_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        hold_d  = hold_q;
        turn_d  = turn_q;
        terr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = OWN;
                    gnt_d       = '0;
                    gnt_d[sel]  = 1'b1;
                    last_d      = sel;
                    hold_d      = '0;
                end
            end
            OWN: begin
                // A release on the last allowed cycle wins over the abort.
                if (bus.done[last_q]) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    turn_d  = '0;
                end else if ((TIMEOUT != 0) && (hold_q == HOLD_LAST)) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    turn_d  = '0;
                    terr_d  = 1'b1;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = IDLE;
                end else begin
                    turn_d  = turn_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.onfi_cen    = 1'b1;
        bus.onfi_cle    = 1'b0;
        bus.onfi_ale    = 1'b0;
        bus.onfi_wen    = 1'b1;
        bus.onfi_dq_o   = '0;
        bus.onfi_dq_en  = 1'b0;
        bus.onfi_dqs_en = 1'b0;
        if (state_q == OWN) begin
            bus.onfi_cen    = 1'b0;
            bus.onfi_cle    = bus.eng_cle[last_q];
            bus.onfi_ale    = bus.eng_ale[last_q];
            bus.onfi_wen    = bus.eng_wen[last_q];
            bus.onfi_dq_o   = bus.eng_dq_o[int'(last_q)*DQ_W +: DQ_W];
            bus.onfi_dq_en  = bus.eng_dq_en[last_q];
            bus.onfi_dqs_en = bus.eng_dqs_en[last_q];
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_onfi_bus_arbiter.sv
// Scoreboard bench for onfi_bus_arbiter: the driver predicts each grant from the round-robin
// rule and pushes it; a negedge monitor pops on every new grant and checks pins, hold time and gaps.
module tb_onfi_bus_arbiter;
    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int DQ_ALL   = N * DW;
    localparam int TURN_CYC = 2;
    localparam int TIMEOUT  = 16;
    localparam int NE       = 29;

    typedef struct {
        int owner;
        int hold;
        bit to;
        int gap;
    } exp_t;

    logic onfi_clk   = 1'b0;
    logic onfi_rst_n = 1'b0;

    onfi_bus_arbiter_if #(.NUM_REQ(N), .DQ_W(DW)) bus ();

    onfi_bus_arbiter #(
        .NUM_REQ (N),
        .DQ_W    (DW),
        .TURN_CYC(TURN_CYC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .onfi_clk  (onfi_clk),
        .onfi_rst_n(onfi_rst_n),
        .bus       (bus)
    );

    always #5 onfi_clk = ~onfi_clk;

    exp_t sb_q[$];
    exp_t cur;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   model_last = N - 1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first requester after the previous owner, wrapping.
    function automatic int rr_pick(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic issue(input logic [N-1:0] pat, input int h, input int gap, output int owner);
        exp_t e;
        bus.req = pat;
        owner   = rr_pick(pat, model_last);
        e.owner = owner;
        e.hold  = (h > TIMEOUT) ? TIMEOUT : h;
        e.to    = (h > TIMEOUT);
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.gnt != '0) begin
                ok = 1'b1;
                break;
            end
            @(posedge onfi_clk); #1;
        end
        if (!ok) check("grant_wait", 64'(bus.gnt != '0), 64'(1));
    endtask

    // Called in OWN cycle 1; owner releases in cycle h unless the timeout fires first.
    task automatic run_owner(input int owner, input int h);
        logic [N-1:0] d;
        for (int c = 1; c <= h && c <= TIMEOUT; c++) begin
            d = '0;
            if (c == h) d[owner] = 1'b1;
            else if (c == 1) d[(owner + 1 + int'($urandom_range(0, N - 2))) % N] = 1'b1;
            bus.done = d;
            @(posedge onfi_clk); #1;
        end
        bus.done = '0;
    endtask

    initial begin
        bus.eng_cle = '0; bus.eng_ale = '0; bus.eng_wen = '1;
        bus.eng_dq_o = '0; bus.eng_dq_en = '0; bus.eng_dqs_en = '0;
        forever begin
            @(posedge onfi_clk); #2;
            bus.eng_cle    = N'($urandom);
            bus.eng_ale    = N'($urandom);
            bus.eng_wen    = N'($urandom);
            bus.eng_dq_o   = DQ_ALL'($urandom);
            bus.eng_dq_en  = N'($urandom);
            bus.eng_dqs_en = N'($urandom);
        end
    end

    // Monitor
    initial begin
        bit          prev_on;
        bit          on;
        bit          have;
        int          hold;
        int          gap;
        logic [13:0] idle_pins;
        logic [13:0] own_pins;
        prev_on = 1'b0; have = 1'b0; hold = 0; gap = -1;
        idle_pins = {1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        forever begin
            @(negedge onfi_clk);
            if (!onfi_rst_n) begin
                prev_on = 1'b0; have = 1'b0; hold = 0; gap = -1;
                check("rst_gnt", 64'(bus.gnt), 64'(0));
                check("rst_pins", 64'({bus.onfi_cen, bus.onfi_cle, bus.onfi_ale, bus.onfi_wen,
                                       bus.onfi_dq_o, bus.onfi_dq_en, bus.onfi_dqs_en}), 64'(idle_pins));
                continue;
            end
            on = (bus.gnt != '0);
            if (on && !prev_on) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'(1));
                if (sb_q.size() != 0) begin
                    cur  = sb_q.pop_front();
                    have = 1'b1;
                    if (cur.gap >= 0) check("ce_gap", 64'(gap), 64'(cur.gap));
                end
                hold = 0;
            end
            if (on) begin
                hold++;
                if (have) begin
                    check("gnt_onehot", 64'(bus.gnt), 64'(1) << cur.owner);
                    own_pins = {1'b0, bus.eng_cle[cur.owner], bus.eng_ale[cur.owner],
                                bus.eng_wen[cur.owner], bus.eng_dq_o[cur.owner*DW +: DW],
                                bus.eng_dq_en[cur.owner], bus.eng_dqs_en[cur.owner]};
                    check("own_pins", 64'({bus.onfi_cen, bus.onfi_cle, bus.onfi_ale, bus.onfi_wen,
                                           bus.onfi_dq_o, bus.onfi_dq_en, bus.onfi_dqs_en}), 64'(own_pins));
                end
                check("own_busy", 64'(bus.busy), 64'(1));
                check("own_terr", 64'(bus.timeout_err), 64'(0));
            end else begin
                if (prev_on) begin
                    if (have) begin
                        check("hold_len", 64'(hold), 64'(cur.hold));
                        check("timeout_err", 64'(bus.timeout_err), 64'(cur.to));
                    end
                    have = 1'b0;
                    gap  = 0;
                end else begin
                    check("terr_quiet", 64'(bus.timeout_err), 64'(0));
                end
                if (gap >= 0) gap++;
                check("idle_pins", 64'({bus.onfi_cen, bus.onfi_cle, bus.onfi_ale, bus.onfi_wen,
                                        bus.onfi_dq_o, bus.onfi_dq_en, bus.onfi_dqs_en}), 64'(idle_pins));
                if (gap >= 1) check("gap_busy", 64'(bus.busy), 64'(gap <= TURN_CYC));
            end
            prev_on = on;
        end
    end

    // Driver and reference model
    initial begin
        logic [N-1:0] pats [NE];
        int           hs   [NE];
        int           cur_owner;
        int           nxt_owner;
        int           cur_h;
        bit           ok;

        pats[0] = 4'b0001; hs[0] = 15;
        for (int i = 1; i <= 4; i++) begin pats[i] = 4'b1111; hs[i] = 4; end
        pats[5] = 4'b1000; hs[5] = 40;
        pats[6] = 4'b1000; hs[6] = TIMEOUT;
        pats[7] = 4'b1001; hs[7] = 1;
        pats[8] = 4'b1001; hs[8] = 3;
        for (int i = 9; i < NE; i++) begin
            pats[i] = N'($urandom_range(1, (1 << N) - 1));
            hs[i]   = int'($urandom_range(1, 22));
        end

        bus.req = '0; bus.done = '0;
        repeat (3) @(posedge onfi_clk);
        #1 onfi_rst_n = 1'b1;
        repeat (3) @(posedge onfi_clk);
        #1;

        nxt_owner = 0;
        issue(pats[0], hs[0], -1, cur_owner);
        cur_h = hs[0];
        for (int e = 0; e < NE; e++) begin
            wait_gnt(ok);
            if (!ok) break;
            model_last = cur_owner;
            if (e < NE - 1) issue(pats[e+1], hs[e+1], TURN_CYC + 1, nxt_owner);
            else bus.req = '0;
            run_owner(cur_owner, cur_h);
            if (e < NE - 1) begin
                cur_owner = nxt_owner;
                cur_h     = hs[e+1];
            end
        end

        // Asynchronous reset in the middle of an ownership.
        repeat (TURN_CYC + 2) @(posedge onfi_clk);
        #1;
        issue(4'b0100, 100, -1, cur_owner);
        wait_gnt(ok);
        repeat (3) @(posedge onfi_clk);
        #3 onfi_rst_n = 1'b0;
        #1;
        check("async_rst_gnt", 64'(bus.gnt), 64'(0));
        check("async_rst_cen", 64'(bus.onfi_cen), 64'(1));
        check("async_rst_busy", 64'(bus.busy), 64'(0));
        sb_q.delete();
        model_last = N - 1;
        bus.req = '0; bus.done = '0;
        repeat (2) @(posedge onfi_clk);
        #1 onfi_rst_n = 1'b1;
        @(posedge onfi_clk); #1;

        // Pointer is back at NUM_REQ-1, so a lone req[3] must wrap around to 3.
        issue(4'b1000, 5, -1, cur_owner);
        wait_gnt(ok);
        bus.req = '0;
        if (ok) run_owner(cur_owner, 5);
        repeat (6) @(posedge onfi_clk);
        #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
